// File: rtl/stim_rotator_if.sv
// Signal bundle for stim_rotator: input stream, result stream, status and flush.
// out_parity is present only when STIM_ROTATOR_PARITY_EN is defined.
interface stim_rotator_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_dir;
   logic [CNT_W-1:0] in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;
   logic [CW-1:0]    fifo_count;
   logic             flush;
`ifdef STIM_ROTATOR_PARITY_EN
   logic             out_parity;
`endif

   modport slave (
`ifdef STIM_ROTATOR_PARITY_EN
      output out_parity,
`endif
      input  in_valid, in_data, in_dir, in_amt, out_ready, flush,
      output in_ready, out_valid, out_data, busy, fifo_count
   );

   modport master (
`ifdef STIM_ROTATOR_PARITY_EN
      input  out_parity,
`endif
      output in_valid, in_data, in_dir, in_amt, out_ready, flush,
      input  in_ready, out_valid, out_data, busy, fifo_count
   );
endinterface

// File: rtl/stim_rotator.sv
// Buffers stimulus words in a small FIFO, rotates each one bit per cycle, then holds the result
// on a valid/ready output. Optional out_parity port enabled by defining STIM_ROTATOR_PARITY_EN.
module stim_rotator #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic           clk,
   input logic           reset_n,
   stim_rotator_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = 1 + CNT_W + WIDTH;

   typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_e;

   state_e           state_q, state_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic             dir_q, dir_d;
   logic             push, pop;
   logic             head_dir;
   logic [CNT_W-1:0] head_amt;
   logic [WIDTH-1:0] head_data;

   function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] w, input logic left);
      return left ? {w[WIDTH-2:0], w[WIDTH-1]} : {w[0], w[WIDTH-1:1]};
   endfunction

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      {head_dir, head_amt, head_data} = mem_q[rd_ptr_q];
      push     = bus.in_valid && ready_q && !bus.flush;
      pop      = (state_q == IDLE) && (count_q != '0) && !bus.flush;
      state_d  = state_q;
      work_d   = work_q;
      step_d   = step_q;
      dir_d    = dir_q;
      out_d    = out_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  work_d = head_data;
                  dir_d  = head_dir;
                  step_d = head_amt;
                  if (head_amt != '0) begin
                     state_d = ROTATE;
                  end else begin
                     state_d = HOLD;
                     out_d   = head_data;
                  end
               end
            end
            ROTATE: begin
               work_d = rot1(work_q, dir_q);
               step_d = step_q - CNT_W'(1);
               if (step_q == CNT_W'(1)) begin
                  state_d = HOLD;
                  out_d   = work_d;
               end
            end
            HOLD: begin
               if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Pointers wrap naturally at DEPTH (power of two); the count tells full from empty.
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
      ready_d = (count_d < CW'(DEPTH));
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         work_q   <= '0;
         out_q    <= '0;
         step_q   <= '0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         work_q   <= work_d;
         out_q    <= out_d;
         step_q   <= step_d;
         dir_q    <= dir_d;
      end
   end

   // NOTE: FIFO storage is not reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.in_dir, bus.in_amt, bus.in_data};
   end

`ifdef STIM_ROTATOR_PARITY_EN
   logic parity_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) parity_q <= 1'b0;
      else          parity_q <= ^out_d;
   end
   assign bus.out_parity = parity_q;
`endif

   assign bus.in_ready   = ready_q;
   assign bus.out_valid  = (state_q == HOLD);
   assign bus.out_data   = out_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_stim_rotator.sv
// Self-checking bench for stim_rotator: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_stim_rotator;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] got_q[$];
   logic [WIDTH-1:0] want_q[$];

   stim_rotator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
   stim_rotator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Rotating by k positions equals k single-bit rotations.
   function automatic logic [WIDTH-1:0] rot_ref(input logic [WIDTH-1:0] d, input logic left,
                                                input int amt);
      int k;
      k = amt % WIDTH;
      if (k == 0) return d;
      if (left) return (d << k) | (d >> (WIDTH - k));
      return (d >> k) | (d << (WIDTH - k));
   endfunction

   // Advances one clock, recording the transfers that the coming edge performs.
   task automatic cycle();
      bit do_push, do_pop;
      do_push = bus.in_valid && bus.in_ready && !bus.flush && reset_n;
      do_pop  = bus.out_valid && bus.out_ready && !bus.flush && reset_n;
      if (do_pop) begin
         got_q.push_back(bus.out_data);
         want_q.push_back(exp_q.size() != 0 ? exp_q.pop_front() : 'x);
      end
      if (bus.flush) exp_q.delete();
      else if (do_push) exp_q.push_back(rot_ref(bus.in_data, bus.in_dir, int'(bus.in_amt)));
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      got_q.delete();
      want_q.delete();
   endtask

   task automatic drive(input logic [WIDTH-1:0] d, input logic dir, input int amt);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_dir   = dir;
      bus.in_amt   = CNT_W'(amt);
   endtask

   // Pushes one word into an idle design and watches it through to the output.
   task automatic run_one(input logic [WIDTH-1:0] d, input logic dir, input int amt,
                          output int first_valid, output logic [WIDTH-1:0] seen,
                          output int busy_cycles, output logic par_seen);
      first_valid = -1;
      busy_cycles = 0;
      seen = 'x;
      par_seen = 1'b0;
      bus.out_ready = 1'b1;
      drive(d, dir, amt);
      cycle();
      bus.in_valid = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         cycle();
         if (bus.busy) busy_cycles++;
         if (bus.out_valid && first_valid < 0) begin
            first_valid = n;
            seen = bus.out_data;
`ifdef STIM_ROTATOR_PARITY_EN
            par_seen = bus.out_parity;
`endif
         end
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dir = 1'b0; bus.in_amt = '0;
      bus.out_ready = 1'b0; bus.flush = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
      checks++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL reset_fifo_count got %0d want 0", bus.fifo_count); end
`ifdef STIM_ROTATOR_PARITY_EN
      checks++; if (bus.out_parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %0b want 0", bus.out_parity); end
`endif
      reset_n = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got %0b want 0", bus.in_ready); end
      cycle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
   endtask

   task automatic test_single_left();
      int fv, bc; logic [WIDTH-1:0] s; logic p;
      clear_model();
      run_one(8'hA5, 1'b1, 1, fv, s, bc, p);
      checks++; if (fv !== 2) begin errors++; $display("FAIL left1_latency got %0d want 2", fv); end
      checks++; if (s !== 8'h4B) begin errors++; $display("FAIL left1_data got %h want 4b", s); end
      checks++; if (bc !== 2) begin errors++; $display("FAIL left1_busy_cycles got %0d want 2", bc); end
`ifdef STIM_ROTATOR_PARITY_EN
      checks++; if (p !== 1'b0) begin errors++; $display("FAIL left1_parity got %0b want 0", p); end
`endif
   endtask

   task automatic test_right_and_pass();
      int fv, bc; logic [WIDTH-1:0] s; logic p;
      clear_model();
      run_one(8'h01, 1'b0, 3, fv, s, bc, p);
      checks++; if (fv !== 4) begin errors++; $display("FAIL right3_latency got %0d want 4", fv); end
      checks++; if (s !== 8'h20) begin errors++; $display("FAIL right3_data got %h want 20", s); end
`ifdef STIM_ROTATOR_PARITY_EN
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL right3_parity got %0b want 1", p); end
`endif
      run_one(8'h01, 1'b0, 0, fv, s, bc, p);
      checks++; if (fv !== 1) begin errors++; $display("FAIL pass_latency got %0d want 1", fv); end
      checks++; if (s !== 8'h01) begin errors++; $display("FAIL pass_data got %h want 01", s); end
      checks++; if (bc !== 1) begin errors++; $display("FAIL pass_busy_cycles got %0d want 1", bc); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] w [6];
      logic d [6];
      int a [6];
      int n;
      clear_model();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         w[i] = WIDTH'($urandom) | WIDTH'(1);
         d[i] = 1'($urandom);
         a[i] = int'($urandom_range(0, (1 << CNT_W) - 1));
      end
      for (int i = 0; i < 5; i++) begin
         drive(w[i], d[i], a[i]);
         cycle();
      end
      drive(w[5], d[5], a[5]);
      n = 0;
      while (!bus.out_valid && n < 12) begin cycle(); n++; end
      cycle();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold got %0b want 1", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %0b want 0", bus.in_ready); end
      checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_fifo_count got %0d want 4", bus.fifo_count); end
      checks++; if (bus.out_data !== rot_ref(w[0], d[0], a[0])) begin errors++; $display("FAIL b2b_hold_data got %h want %h", bus.out_data, rot_ref(w[0], d[0], a[0])); end
      bus.out_ready = 1'b1;
      n = 0;
      while (got_q.size() < 6 && n < 100) begin
         automatic bit pushed = bus.in_valid && bus.in_ready;
         cycle();
         if (pushed) bus.in_valid = 1'b0;
         n++;
      end
      checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL b2b_out_count got %0d want 6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== rot_ref(w[i], d[i], a[i])) begin
            errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, got_q[i], rot_ref(w[i], d[i], a[i]));
         end
      end
      bus.in_valid = 1'b0;
      repeat (2) cycle();
   endtask

   task automatic test_reset_mid();
      int vcount;
      clear_model();
      bus.out_ready = 1'b0;
      drive(8'hF0, 1'($urandom), 5);
      cycle();
      drive(8'h3C, 1'b1, 2);
      cycle();
      bus.in_valid = 1'b0;
      cycle();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %0b want 1", bus.busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %0b want 0", bus.out_valid); end
      checks++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL midrst_fifo_count got %0d want 0", bus.fifo_count); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL midrst_out_data got %h want 00", bus.out_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", bus.busy); end
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      clear_model();
      bus.out_ready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 15; i++) begin
         cycle();
         if (bus.out_valid) vcount++;
      end
      checks++; if (vcount !== 0) begin errors++; $display("FAIL midrst_stale_valid got %0d want 0", vcount); end
      checks++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL midrst_post_count got %0d want 0", bus.fifo_count); end
   endtask

   task automatic test_flush();
      logic [WIDTH-1:0] a_res, f_res;
      int n;
      clear_model();
      bus.out_ready = 1'b0;
      a_res = rot_ref(8'h96, 1'b1, 2);
      drive(8'h96, 1'b1, 2); cycle();
      drive(8'h11, 1'b0, 1); cycle();
      drive(8'h22, 1'b1, 3); cycle();
      drive(8'h33, 1'b0, 4); cycle();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 12) begin cycle(); n++; end
      checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", bus.fifo_count); end
      bus.flush = 1'b1;
      drive(8'h77, 1'b1, 1);
      cycle();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.fifo_count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b want 0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", bus.busy); end
      checks++; if (bus.out_data !== a_res) begin errors++; $display("FAIL flush_data_kept got %h want %h", bus.out_data, a_res); end
      repeat (3) cycle();
      checks++; if (bus.fifo_count !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL flush_push_dropped got count %0d busy %0b want 0 0", bus.fifo_count, bus.busy); end
      f_res = rot_ref(8'hC3, 1'b0, 6);
      bus.out_ready = 1'b1;
      drive(8'hC3, 1'b0, 6);
      cycle();
      bus.in_valid = 1'b0;
      n = 0;
      while (got_q.size() < 1 && n < 20) begin cycle(); n++; end
      repeat (4) cycle();
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL flush_after_count got %0d want 1", got_q.size()); end
      checks++; if (got_q.size() > 0 && got_q[0] !== f_res) begin errors++; $display("FAIL flush_after_data got %h want %h", got_q[0], f_res); end
   endtask

   task automatic test_random();
      int n;
      clear_model();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 600; c++) begin
         automatic bit pushed = bus.in_valid && bus.in_ready && !bus.flush;
         if (!bus.in_valid || pushed) begin
            if ($urandom_range(0, 2) != 0)
               drive(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, (1 << CNT_W) - 1)));
            else
               bus.in_valid = 1'b0;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush = ($urandom_range(0, 63) == 0);
         cycle();
      end
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 200) begin cycle(); n++; end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); end
      checks++; if (got_q.size() < 20) begin errors++; $display("FAIL rand_volume got %0d outputs want at least 20", got_q.size()); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== want_q[i]) begin
            errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], want_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_left();
      test_right_and_pass();
      test_back_to_back();
      test_reset_mid();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stim_rotator.md
Name: stim_rotator

Overview:
- Consumer stage directly downstream of the stimulus generator.
- Accepts 8-bit stimulus words with a direction and a rotate amount over a valid/ready handshake, and buffers them in a small FIFO.
- Rotates each word one bit per cycle in a work register, then presents the result on a valid/ready output.
- Feeds result checkers and display logic.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- CNT_W, 3, width of the rotate-amount field.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  WIDTH  stimulus word.
- in_dir  input  1  1 = rotate left, 0 = rotate right.
- in_amt  input  CNT_W  number of single-bit rotate steps.
- out_valid  output  1  rotated result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  rotated word.
- busy  output  1  state is not IDLE.
- fifo_count  output  $clog2(DEPTH+1)  occupied FIFO entries.
- flush  input  1  synchronous abort and clear.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; FIFO pointers and count = 0; work register = 0; step counter = 0.
  - Outputs: out_valid=0, out_data=0, busy=0, fifo_count=0, in_ready=0 while reset is asserted.
  - in_ready rises on the first edge after reset_n deasserts.
- Input handshake:
  - A push occurs on an edge where in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH), taken from the registered count; there is no combinational path from the pop.
  - {in_dir, in_amt, in_data} are stored together as one entry.
- States:
  - IDLE:
    - If fifo_count > 0, pop the head into the work register and load the step counter with amt.
    - Next state: ROTATE if amt != 0, else HOLD.
  - ROTATE:
    - Each edge rotates the work register by one bit (left: {w[W-2:0], w[W-1]}; right: {w[0], w[W-1:1]}) and decrements the counter.
    - The edge on which the counter goes 1->0 moves the state to HOLD.
  - HOLD:
    - out_valid=1 and out_data = work register.
    - Data is stable while out_valid && !out_ready.
    - On out_ready, go to IDLE. There is no same-cycle re-pop; the next pop happens on the following edge.
- out_data keeps its last value when out_valid=0.
- Latency: a word pushed at edge T into an empty FIFO with the engine in IDLE is popped at T+1; out_valid is high after edge T+1+amt.
- amt is a plain step count:
  - amt=0 gives pass-through.
  - Amounts of WIDTH or more wrap naturally; for example WIDTH=8 with amt=8 needs CNT_W=4 and returns the original word.
- Simultaneous push and pop in IDLE: count stays unchanged. A push with a full FIFO is impossible because in_ready=0.
- Pointers wrap modulo DEPTH; the count distinguishes full from empty.
- flush (synchronous, highest priority after reset):
  - Count and pointers go to 0, state goes to IDLE, out_valid goes to 0.
  - Any word in ROTATE or HOLD is dropped.
  - A push in the same cycle as flush is discarded.
- Mid-operation reset: everything returns to reset values immediately; no partial output.

Optional Feature:
- Macro: STIM_ROTATOR_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = ^out_data, registered together with out_data.
  - Reset value 0.
  - Valid only while out_valid=1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single word 8'hA5, dir=1, amt=1, out_ready=1, pushed at edge T -> out_valid after T+2 with out_data=8'h4B; busy high for 2 cycles.
- 8'h01, dir=0, amt=3 -> out_data=8'h20 after T+4; with amt=0 -> 8'h01 after T+1, no ROTATE cycles.
- out_ready held 0; push 6 words back-to-back:
  - 1 is held in HOLD and 4 fill the FIFO.
  - in_ready=0 and fifo_count=4 with the 6th pending.
  - Release out_ready -> results appear in push order.
- reset_n pulsed low during ROTATE of 8'hF0 (amt=5) -> out_valid=0, fifo_count=0, out_data=0 immediately; no stale output after release.
- flush asserted with 3 entries queued and one word in HOLD -> next cycle fifo_count=0, out_valid=0, busy=0; a push coincident with flush is not stored.
- With STIM_ROTATOR_PARITY_EN: 8'h4B -> out_parity=0; 8'h20 -> out_parity=1.
